axc_error_scanner: RTL and testbench

- Sequential characterisation controller for one approximate adder netlist with 2*IN_W inputs and OUT_W outputs.
- Walks the adder's full input space and drives each vector onto the netlist's inputs.
- After a settle window, samples the approximate sum and compares it with the exact sum.
- Accumulates worst-case error, total absolute error and mismatch count, then reports pass/fail against a runtime error threshold.
- Sits beside the flat combinational approximate circuits as their on-chip sign-off engine.

---
 rtl/axc_pkg.sv | 31 +++
 rtl/axc_err_calc.sv | 26 ++
 rtl/axc_error_scanner.sv | 189 ++++++++++++++++++
 tb/tb_axc_error_scanner.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axc_pkg.sv
// Shared FSM state type and sizing/arithmetic helpers for the approximate-adder error scanner.
package axc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    EVAL  = 2'd2,
    DONE  = 2'd3
  } axc_state_e;

  localparam int unsigned ABS_W    = 32;
  localparam int unsigned SETTLE_W = 4;

  function automatic int unsigned n_vec(input int unsigned in_w);
    return 32'd1 << (2 * in_w);
  endfunction

  function automatic int unsigned err_sum_w(input int unsigned in_w, input int unsigned out_w);
    return out_w + 2 * in_w;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned in_w);
    return 2 * in_w + 1;
  endfunction

  function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                input logic [ABS_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/axc_err_calc.sv
// Combinational error datapath: exact sum of the current vector versus the sampled approximate sum.
module axc_err_calc
  import axc_pkg::*;
#(
  parameter int unsigned IN_W  = 2,
  parameter int unsigned OUT_W = 3
) (
  input  logic [2*IN_W-1:0] vec_i,
  input  logic [OUT_W-1:0]  dut_out_i,
  output logic [OUT_W-1:0]  err_c_o,
  output logic              mismatch_c_o
);

  logic [IN_W-1:0]  op_a;
  logic [IN_W-1:0]  op_b;
  logic [OUT_W-1:0] exact_c;

  always_comb begin
    op_a         = vec_i[IN_W-1:0];
    op_b         = vec_i[2*IN_W-1:IN_W];
    exact_c      = OUT_W'(op_a) + OUT_W'(op_b);
    err_c_o      = OUT_W'(abs_diff(ABS_W'(dut_out_i), ABS_W'(exact_c)));
    mismatch_c_o = (dut_out_i != exact_c);
  end

endmodule

// File: rtl/axc_error_scanner.sv
// Exhaustive error characterisation of one approximate adder: drive, settle, sample, accumulate.
// Optional AXC_ERROR_SCANNER_WORST_VEC_EN adds a worst_vec output capturing the vector of the worst error.
module axc_error_scanner
  import axc_pkg::*;
#(
  parameter int unsigned IN_W   = 2,
  parameter int unsigned OUT_W  = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [OUT_W-1:0]        et_thresh,
  output logic [2*IN_W-1:0]       dut_in,
  input  logic [OUT_W-1:0]        dut_out,
  output logic                    busy,
  output logic                    done,
  output logic [OUT_W-1:0]        max_err,
  output logic [OUT_W+2*IN_W-1:0] err_sum,
  output logic [2*IN_W:0]         err_count,
  output logic                    pass
`ifdef AXC_ERROR_SCANNER_WORST_VEC_EN
  ,
  output logic [2*IN_W-1:0]       worst_vec
`endif
);

  localparam int unsigned VEC_W     = 2 * IN_W;
  localparam int unsigned N_VEC     = n_vec(IN_W);
  localparam int unsigned ERR_SUM_W = err_sum_w(IN_W, OUT_W);
  localparam int unsigned CNT_W     = cnt_w(IN_W);

  if (OUT_W != IN_W + 1) begin : g_bad_out_w
    $error("axc_error_scanner: OUT_W must equal IN_W+1");
  end
  if (SETTLE == 0 || SETTLE > 15) begin : g_bad_settle
    $error("axc_error_scanner: SETTLE must be in 1..15");
  end

  axc_state_e           state_q,     state_d;
  logic [VEC_W-1:0]     vec_q,       vec_d;
  logic [SETTLE_W-1:0]  settle_q,    settle_d;
  logic [OUT_W-1:0]     thresh_q,    thresh_d;
  logic [VEC_W-1:0]     dut_in_q,    dut_in_d;
  logic                 busy_q,      busy_d;
  logic                 done_q,      done_d;
  logic [OUT_W-1:0]     max_err_q,   max_err_d;
  logic [ERR_SUM_W-1:0] err_sum_q,   err_sum_d;
  logic [CNT_W-1:0]     err_count_q, err_count_d;
  logic                 pass_q,      pass_d;
`ifdef AXC_ERROR_SCANNER_WORST_VEC_EN
  logic [VEC_W-1:0]     worst_vec_q, worst_vec_d;
`endif

  logic [OUT_W-1:0] err_c;
  logic             mismatch_c;

  // vec_q equals the vector on dut_in throughout DRIVE/EVAL, so it is the sampled vector.
  axc_err_calc #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_err_calc (
    .vec_i        (vec_q),
    .dut_out_i    (dut_out),
    .err_c_o      (err_c),
    .mismatch_c_o (mismatch_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      settle_q    <= '0;
      thresh_q    <= '0;
      dut_in_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      max_err_q   <= '0;
      err_sum_q   <= '0;
      err_count_q <= '0;
      pass_q      <= 1'b0;
`ifdef AXC_ERROR_SCANNER_WORST_VEC_EN
      worst_vec_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      settle_q    <= settle_d;
      thresh_q    <= thresh_d;
      dut_in_q    <= dut_in_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      max_err_q   <= max_err_d;
      err_sum_q   <= err_sum_d;
      err_count_q <= err_count_d;
      pass_q      <= pass_d;
`ifdef AXC_ERROR_SCANNER_WORST_VEC_EN
      worst_vec_q <= worst_vec_d;
`endif
    end
  end

  // Next-state and registered-output logic; dut_in_d follows the vector of the next state.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    settle_d    = settle_q;
    thresh_d    = thresh_q;
    dut_in_d    = '0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    max_err_d   = max_err_q;
    err_sum_d   = err_sum_q;
    err_count_d = err_count_q;
    pass_d      = pass_q;
`ifdef AXC_ERROR_SCANNER_WORST_VEC_EN
    worst_vec_d = worst_vec_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = DRIVE;
          thresh_d    = et_thresh;
          vec_d       = '0;
          settle_d    = '0;
          busy_d      = 1'b1;
          max_err_d   = '0;
          err_sum_d   = '0;
          err_count_d = '0;
          pass_d      = 1'b0;
`ifdef AXC_ERROR_SCANNER_WORST_VEC_EN
          worst_vec_d = '0;
`endif
        end
      end

      DRIVE: begin
        dut_in_d = vec_q;
        settle_d = settle_q + SETTLE_W'(1);
        if (settle_q == SETTLE_W'(SETTLE - 1)) begin
          state_d = EVAL;
        end
      end

      EVAL: begin
        err_sum_d = err_sum_q + ERR_SUM_W'(err_c);
        if (err_c > max_err_q) begin
          max_err_d   = err_c;
`ifdef AXC_ERROR_SCANNER_WORST_VEC_EN
          worst_vec_d = vec_q;
`endif
        end
        if (mismatch_c) begin
          err_count_d = err_count_q + CNT_W'(1);
        end
        if (vec_q == VEC_W'(N_VEC - 1)) begin
          state_d = DONE;
        end else begin
          vec_d    = vec_q + VEC_W'(1);
          dut_in_d = vec_q + VEC_W'(1);
          settle_d = '0;
          state_d  = DRIVE;
        end
      end

      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (max_err_q <= thresh_q);
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign dut_in    = dut_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign max_err   = max_err_q;
  assign err_sum   = err_sum_q;
  assign err_count = err_count_q;
  assign pass      = pass_q;
`ifdef AXC_ERROR_SCANNER_WORST_VEC_EN
  assign worst_vec = worst_vec_q;
`endif

endmodule

// File: tb/tb_axc_error_scanner.sv
// Scoreboard bench for axc_error_scanner: two instances (SETTLE=1 and SETTLE=3) scanning modelled adders.
module tb_axc_error_scanner;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start1 = 1'b0;
  logic       start3 = 1'b0;
  logic [2:0] et_thresh = 3'd0;

  logic [3:0] dut_in1, dut_in3;
  logic [2:0] dut_out1, dut_out3;
  logic       busy1, busy3, done1, done3, pass1, pass3;
  logic [2:0] max_err1, max_err3;
  logic [6:0] err_sum1, err_sum3;
  logic [4:0] err_count1, err_count3;
`ifdef AXC_ERROR_SCANNER_WORST_VEC_EN
  logic [3:0] worst_vec1, worst_vec3;
`endif

  int mode      = 0;   // 0: exact adder, 1: output stuck at 0, 2: output stuck at 7
  int cyc       = 0;
  int n_applied = 0;
  int n_miss    = 0;

  typedef struct {
    int start_cyc;
    int lat;
    int max_err;
    int err_sum;
    int err_count;
    int pass;
    int worst;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  function automatic logic [2:0] model(input int m, input logic [3:0] v);
    logic [1:0] a;
    logic [1:0] b;
    a = v[1:0];
    b = v[3:2];
    case (m)
      1:       return 3'd0;
      2:       return 3'd7;
      default: return 3'(a) + 3'(b);
    endcase
  endfunction

  assign dut_out1 = model(mode, dut_in1);
  assign dut_out3 = model(0, dut_in3);

  axc_error_scanner #(.IN_W(2), .OUT_W(3), .SETTLE(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start1),
    .et_thresh (et_thresh),
    .dut_in    (dut_in1),
    .dut_out   (dut_out1),
    .busy      (busy1),
    .done      (done1),
    .max_err   (max_err1),
    .err_sum   (err_sum1),
    .err_count (err_count1),
    .pass      (pass1)
`ifdef AXC_ERROR_SCANNER_WORST_VEC_EN
    ,
    .worst_vec (worst_vec1)
`endif
  );

  axc_error_scanner #(.IN_W(2), .OUT_W(3), .SETTLE(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start3),
    .et_thresh (et_thresh),
    .dut_in    (dut_in3),
    .dut_out   (dut_out3),
    .busy      (busy3),
    .done      (done3),
    .max_err   (max_err3),
    .err_sum   (err_sum3),
    .err_count (err_count3),
    .pass      (pass3)
`ifdef AXC_ERROR_SCANNER_WORST_VEC_EN
    ,
    .worst_vec (worst_vec3)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_applied++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pops the expected result for an instance whenever it pulses done.
  task automatic monitor(input int sel);
    exp_t e;
    int   a_max, a_sum, a_cnt, a_pass, a_busy, a_worst;
    forever begin
      @(negedge clk);
      if ((sel == 1 && done1) || (sel == 3 && done3)) begin
        if ((sel == 1 && q1.size() == 0) || (sel == 3 && q3.size() == 0)) begin
          n_applied++;
          n_miss++;
          $display("FAIL unexpected_done inst%0d: got done at cycle %0d, expected none", sel, cyc);
        end else begin
          if (sel == 1) begin
            e = q1.pop_front();
            a_max = int'(max_err1); a_sum = int'(err_sum1); a_cnt = int'(err_count1);
            a_pass = int'(pass1); a_busy = int'(busy1);
`ifdef AXC_ERROR_SCANNER_WORST_VEC_EN
            a_worst = int'(worst_vec1);
`else
            a_worst = e.worst;
`endif
          end else begin
            e = q3.pop_front();
            a_max = int'(max_err3); a_sum = int'(err_sum3); a_cnt = int'(err_count3);
            a_pass = int'(pass3); a_busy = int'(busy3);
`ifdef AXC_ERROR_SCANNER_WORST_VEC_EN
            a_worst = int'(worst_vec3);
`else
            a_worst = e.worst;
`endif
          end
          check($sformatf("latency_inst%0d", sel), cyc - e.start_cyc, e.lat);
          check($sformatf("max_err_inst%0d", sel), a_max, e.max_err);
          check($sformatf("err_sum_inst%0d", sel), a_sum, e.err_sum);
          check($sformatf("err_count_inst%0d", sel), a_cnt, e.err_count);
          check($sformatf("pass_inst%0d", sel), a_pass, e.pass);
          check($sformatf("busy_at_done_inst%0d", sel), a_busy, 0);
`ifdef AXC_ERROR_SCANNER_WORST_VEC_EN
          check($sformatf("worst_vec_inst%0d", sel), a_worst, e.worst);
`endif
        end
      end
    end
  endtask

  // One scan; start re-pulses at offsets p0..p2 and an optional threshold change at offset 10.
  task automatic scan(input int sel, input int m, input int thr,
                      input int x_max, input int x_sum, input int x_cnt,
                      input int x_pass, input int x_worst,
                      input int p0, input int p1, input int p2, input int new_thr);
    exp_t e;
    int   sc;
    bit   seen;
    int   off;
    @(negedge clk);
    mode      = m;
    et_thresh = 3'(thr);
    if (sel == 1) start1 = 1'b1; else start3 = 1'b1;
    sc          = cyc + 1;
    e.start_cyc = sc;
    e.lat       = 16 * ((sel == 1) ? 2 : 4) + 1;
    e.max_err   = x_max;
    e.err_sum   = x_sum;
    e.err_count = x_cnt;
    e.pass      = x_pass;
    e.worst     = x_worst;
    if (sel == 1) q1.push_back(e); else q3.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      off = cyc - sc;
      if (sel == 1) start1 = (off == p0 || off == p1 || off == p2);
      else          start3 = (off == p0 || off == p1 || off == p2);
      if (new_thr >= 0 && off == 10) et_thresh = 3'(new_thr);
      if (off == 0) check("busy_after_start", int'((sel == 1) ? busy1 : busy3), 1);
      if (sel == 3 && off < 64) check("dut_in_hold", int'(dut_in3), off / 4);
      if ((sel == 1 && done1) || (sel == 3 && done3)) seen = 1'b1;
    end
    start1 = 1'b0;
    start3 = 1'b0;
    if (!seen) begin
      n_applied++;
      n_miss++;
      $display("FAIL done_timeout inst%0d: got no done, expected done within 200 cycles", sel);
    end else begin
      @(negedge clk);
      check("idle_after_done", int'((sel == 1) ? busy1 : busy3), 0);
    end
  endtask

  initial begin
    int sc;
    fork
      monitor(1);
      monitor(3);
    join_none

    repeat (3) @(negedge clk);
    check("rst_busy",      int'(busy1), 0);
    check("rst_done",      int'(done1), 0);
    check("rst_dut_in",    int'(dut_in1), 0);
    check("rst_max_err",   int'(max_err1), 0);
    check("rst_err_sum",   int'(err_sum1), 0);
    check("rst_err_count", int'(err_count1), 0);
    check("rst_pass",      int'(pass1), 0);
    check("rst_busy3",     int'(busy3), 0);
    rst_n = 1'b1;

    scan(1, 0, 0, 0,  0,  0, 1, 0,  -1, -1, -1, -1);
    scan(1, 1, 5, 6, 48, 15, 0, 15, -1, -1, -1, -1);
    scan(1, 2, 7, 7, 64, 16, 1, 0,  -1, -1, -1, -1);
    scan(1, 1, 5, 6, 48, 15, 0, 15,  5, 20, 32,  7);
    scan(1, 1, 6, 6, 48, 15, 1, 15, -1, -1, -1, -1);

    // Abort a stuck-at-0 scan after five evaluated vectors.
    @(negedge clk);
    mode      = 1;
    et_thresh = 3'd0;
    start1    = 1'b1;
    sc        = cyc + 1;
    @(negedge clk);
    start1 = 1'b0;
    while (cyc < sc + 10) @(negedge clk);
    check("pre_reset_err_sum", int'(err_sum1), 7);
    check("pre_reset_max_err", int'(max_err1), 3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy",      int'(busy1), 0);
    check("abort_dut_in",    int'(dut_in1), 0);
    check("abort_max_err",   int'(max_err1), 0);
    check("abort_err_sum",   int'(err_sum1), 0);
    check("abort_err_count", int'(err_count1), 0);
    check("abort_done",      int'(done1), 0);
    repeat (40) @(negedge clk);
    check("abort_no_done", int'(done1), 0);

    scan(1, 2, 7, 7, 64, 16, 1, 0, -1, -1, -1, -1);
    scan(3, 0, 0, 0,  0,  0, 1, 0, -1, -1, -1, -1);

    repeat (5) @(negedge clk);
    check("pending_expect_inst1", q1.size(), 0);
    check("pending_expect_inst3", q3.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
